detector_jogada: RTL and testbench

DETECTOR_JOGADA -- requirements
Module: detector_jogada

---
 rtl/detector_jogada.sv | 113 +++++++++++
 tb/tb_detector_jogada.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/detector_jogada.sv
// Switch-press detector: debounces the 4-bit switch bank, registers one play
// per press and waits for a debounced release before accepting the next one.
module detector_jogada #(
    parameter int DEBOUNCE_CICLOS = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       habilita,
    input  logic [3:0] chaves,
    output logic       jogada_feita,
    output logic [3:0] jogada,
    output logic       jogada_valida,
    output logic [2:0] db_estado
);

    typedef enum logic [1:0] {
        ESPERA   = 2'd0,
        FILTRA   = 2'd1,
        REGISTRA = 2'd2,
        SOLTA    = 2'd3
    } estado_t;

    localparam logic [7:0] LIMITE = 8'(DEBOUNCE_CICLOS);

    estado_t    estado, estado_prox;
    logic [7:0] contagem, contagem_prox, contagem_inc;
    logic [3:0] amostra, amostra_prox;
    logic       carrega_jogada;
    logic       um_quente;

    // Saturating increment: the stable counter must never wrap back to zero.
    assign contagem_inc = (contagem == 8'hFF) ? contagem : contagem + 8'd1;
    assign um_quente    = (amostra != 4'd0) && ((amostra & (amostra - 4'd1)) == 4'd0);

    always_comb begin
        estado_prox    = estado;
        contagem_prox  = contagem;
        amostra_prox   = amostra;
        carrega_jogada = 1'b0;
        case (estado)
            ESPERA: begin
                if (habilita && (chaves != 4'd0)) begin
                    estado_prox   = FILTRA;
                    amostra_prox  = chaves;
                    contagem_prox = 8'd1;
                end
            end
            FILTRA: begin
                if (!habilita || (chaves == 4'd0)) begin
                    estado_prox   = ESPERA;
                    contagem_prox = 8'd0;
                end else if (chaves != amostra) begin
                    amostra_prox  = chaves;
                    contagem_prox = 8'd1;
                end else begin
                    contagem_prox = contagem_inc;
                    if (contagem_inc >= LIMITE) begin
                        estado_prox    = REGISTRA;
                        carrega_jogada = 1'b1;
                    end
                end
            end
            REGISTRA: begin
                estado_prox   = SOLTA;
                contagem_prox = 8'd0;
            end
            SOLTA: begin
                // Release filter: only a run of zero samples returns to idle.
                if (chaves == 4'd0) begin
                    contagem_prox = contagem_inc;
                    if (contagem_inc >= LIMITE) begin
                        estado_prox   = ESPERA;
                        contagem_prox = 8'd0;
                    end
                end else begin
                    contagem_prox = 8'd0;
                end
            end
            default: begin
                estado_prox   = ESPERA;
                contagem_prox = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            estado        <= ESPERA;
            contagem      <= 8'd0;
            amostra       <= 4'd0;
            jogada        <= 4'd0;
            jogada_valida <= 1'b0;
        end else begin
            estado   <= estado_prox;
            contagem <= contagem_prox;
            amostra  <= amostra_prox;
            if (carrega_jogada) begin
                jogada        <= amostra;
                jogada_valida <= um_quente;
            end
        end
    end

    // jogada_feita is a one-cycle strobe; jogada/jogada_valida are valid with it and held after.
    assign jogada_feita = (estado == REGISTRA);
    assign db_estado    = {1'b0, estado};

    a_registra_um_ciclo: assert property (
        @(posedge clock) disable iff (!reset) (estado == REGISTRA) |=> (estado == SOLTA));
    a_contagem_limite: assert property (
        @(posedge clock) disable iff (!reset) (contagem <= LIMITE));

endmodule

// File: tb/tb_detector_jogada.sv
// Directed bench for detector_jogada: per-cycle checks of the strobe and state
// code, plus a scoreboard matching every registered play against expectations.
module tb_detector_jogada;

    logic       clock = 1'b0;
    logic       reset;
    logic       habilita;
    logic [3:0] chaves;
    logic       jogada_feita;
    logic [3:0] jogada;
    logic       jogada_valida;
    logic [2:0] db_estado;

    int checks = 0;
    int errors = 0;
    int pulsos = 0;
    logic [4:0] exp_q[$];

    detector_jogada #(.DEBOUNCE_CICLOS(4)) dut (
        .clock         (clock),
        .reset         (reset),
        .habilita      (habilita),
        .chaves        (chaves),
        .jogada_feita  (jogada_feita),
        .jogada        (jogada),
        .jogada_valida (jogada_valida),
        .db_estado     (db_estado)
    );

    always #10 clock = ~clock;

    task automatic check(input string nome, input int atual, input int esperado);
        checks++;
        if (atual != esperado) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", nome, atual, esperado);
        end
    endtask

    // Called at a negedge: apply inputs, let one rising edge pass, return at the next negedge.
    task automatic ciclo(input logic h, input logic [3:0] c);
        habilita = h;
        chaves   = c;
        @(negedge clock);
    endtask

    // Pulse expected only on cycle 'n_pulso' (1-based); db_estado given per cycle.
    task automatic sequencia(input string nome, input logic h, input logic [3:0] c,
                             input int n, input int n_pulso);
        for (int i = 1; i <= n; i++) begin
            ciclo(h, c);
            check({nome, "_feita"}, int'(jogada_feita), (i == n_pulso) ? 1 : 0);
        end
    endtask

    task automatic solta();
        for (int i = 1; i <= 5; i++) ciclo(1'b1, 4'd0);
        check("solta_estado", int'(db_estado), 0);
    endtask

    // Monitor: every strobe must match the oldest outstanding expectation.
    always @(negedge clock) begin
        if (jogada_feita === 1'b1) begin
            pulsos++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL pulso_inesperado actual=%b/%b expected=none", jogada, jogada_valida);
            end else begin
                logic [4:0] e;
                e = exp_q.pop_front();
                if ({jogada, jogada_valida} !== e) begin
                    errors++;
                    $display("FAIL pulso_dados actual=%b/%b expected=%b/%b",
                             jogada, jogada_valida, e[4:1], e[0]);
                end
            end
        end
    end

    initial begin
        int est_limpa[8] = '{1, 1, 1, 2, 3, 3, 3, 3};
        int est_solta[5] = '{3, 3, 3, 0, 0};
        int p0;

        reset = 1'b0; habilita = 1'b0; chaves = 4'd0;
        @(negedge clock);
        @(negedge clock);

        // Reset with a key held: everything idle.
        reset = 1'b0;
        ciclo(1'b1, 4'b0100);
        check("reset_feita", int'(jogada_feita), 0);
        check("reset_jogada", int'(jogada), 0);
        check("reset_valida", int'(jogada_valida), 0);
        check("reset_estado", int'(db_estado), 0);
        reset = 1'b1;
        ciclo(1'b1, 4'd0);

        // Clean press then release.
        exp_q.push_back({4'b0100, 1'b1});
        for (int i = 1; i <= 8; i++) begin
            ciclo(1'b1, 4'b0100);
            check("limpa_feita", int'(jogada_feita), (i == 4) ? 1 : 0);
            check("limpa_estado", int'(db_estado), est_limpa[i-1]);
        end
        for (int i = 1; i <= 5; i++) begin
            ciclo(1'b1, 4'd0);
            check("limpa_solta_estado", int'(db_estado), est_solta[i-1]);
            check("limpa_solta_feita", int'(jogada_feita), 0);
        end
        check("limpa_jogada", int'(jogada), 4'b0100);
        check("limpa_valida", int'(jogada_valida), 1);

        // Glitch: two samples then zero, nothing registered.
        sequencia("glitch", 1'b1, 4'b0100, 2, 0);
        check("glitch_filtra", int'(db_estado), 1);
        ciclo(1'b1, 4'd0);
        check("glitch_estado", int'(db_estado), 0);
        check("glitch_feita", int'(jogada_feita), 0);
        ciclo(1'b1, 4'd0);
        check("glitch_jogada", int'(jogada), 4'b0100);

        // Value change mid-filter restarts the count.
        exp_q.push_back({4'b0010, 1'b1});
        sequencia("troca_a", 1'b1, 4'b0100, 2, 0);
        sequencia("troca_b", 1'b1, 4'b0010, 5, 4);
        solta();
        check("troca_jogada", int'(jogada), 4'b0010);

        // Multi-bit press registered but flagged invalid.
        exp_q.push_back({4'b0110, 1'b0});
        sequencia("invalida", 1'b1, 4'b0110, 5, 4);
        solta();
        check("invalida_jogada", int'(jogada), 4'b0110);
        check("invalida_valida", int'(jogada_valida), 0);

        // Enable gating, then enable raised with the key still held.
        for (int i = 1; i <= 6; i++) begin
            ciclo(1'b0, 4'b1000);
            check("gate_feita", int'(jogada_feita), 0);
            check("gate_estado", int'(db_estado), 0);
        end
        exp_q.push_back({4'b1000, 1'b1});
        sequencia("gate_hab", 1'b1, 4'b1000, 6, 4);
        solta();
        check("gate_jogada", int'(jogada), 4'b1000);

        // Long hold yields exactly one pulse.
        p0 = pulsos;
        exp_q.push_back({4'b0001, 1'b1});
        sequencia("longo", 1'b1, 4'b0001, 20, 4);
        check("longo_estado", int'(db_estado), 3);
        solta();
        check("longo_pulsos", pulsos - p0, 1);

        // Reset during the strobe cuts it; a held key after release is a new press.
        exp_q.push_back({4'b0001, 1'b1});
        sequencia("corte", 1'b1, 4'b0001, 4, 4);
        reset = 1'b0;
        ciclo(1'b1, 4'b0001);
        check("corte_feita", int'(jogada_feita), 0);
        check("corte_estado", int'(db_estado), 0);
        check("corte_jogada", int'(jogada), 0);
        check("corte_valida", int'(jogada_valida), 0);
        reset = 1'b1;
        exp_q.push_back({4'b0001, 1'b1});
        sequencia("pos_reset", 1'b1, 4'b0001, 5, 4);
        check("pos_reset_estado", int'(db_estado), 3);
        solta();

        check("fila_vazia", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
